// File: rtl/rob_result_buffer_if.sv
// Issue / CDB / query / commit bundle for the reorder buffer.
// The master side (issue and forwarding logic) drives requests; the ROB is the slave.
interface rob_result_buffer_if #(
    parameter int ID_W   = 4,
    parameter int DATA_W = 32
);
    logic              flush;
    logic              alloc_valid;
    logic [4:0]        alloc_rd;
    logic [ID_W-1:0]   alloc_rob_id;
    logic              rob_full;

    logic              valid_from_rs_cdb;
    logic [ID_W-1:0]   rob_id_from_rs_cdb;
    logic [DATA_W-1:0] result_from_rs_cdb;
    logic              valid_from_ls_cdb;
    logic [ID_W-1:0]   rob_id_from_ls_cdb;
    logic [DATA_W-1:0] result_from_ls_cdb;

    logic [ID_W-1:0]   Q1_query;
    logic [ID_W-1:0]   Q2_query;
    logic              Q1_ready_from_rob;
    logic              Q2_ready_from_rob;
    logic [DATA_W-1:0] V1_result_from_rob;
    logic [DATA_W-1:0] V2_result_from_rob;

    logic              commit_valid;
    logic [ID_W-1:0]   commit_rob_id;
    logic [4:0]        commit_rd;
    logic [DATA_W-1:0] commit_value;

    modport master (
        output flush, alloc_valid, alloc_rd,
        output valid_from_rs_cdb, rob_id_from_rs_cdb, result_from_rs_cdb,
        output valid_from_ls_cdb, rob_id_from_ls_cdb, result_from_ls_cdb,
        output Q1_query, Q2_query,
        input  alloc_rob_id, rob_full,
        input  Q1_ready_from_rob, Q2_ready_from_rob, V1_result_from_rob, V2_result_from_rob,
        input  commit_valid, commit_rob_id, commit_rd, commit_value
    );

    modport slave (
        input  flush, alloc_valid, alloc_rd,
        input  valid_from_rs_cdb, rob_id_from_rs_cdb, result_from_rs_cdb,
        input  valid_from_ls_cdb, rob_id_from_ls_cdb, result_from_ls_cdb,
        input  Q1_query, Q2_query,
        output alloc_rob_id, rob_full,
        output Q1_ready_from_rob, Q2_ready_from_rob, V1_result_from_rob, V2_result_from_rob,
        output commit_valid, commit_rob_id, commit_rd, commit_value
    );
endinterface

// File: rtl/rob_result_buffer.sv
// Circular reorder buffer: in-order allocation, dual-CDB result capture,
// combinational operand-ready queries and single in-order commit per cycle.
module rob_result_buffer #(
    parameter int ID_W   = 4,
    parameter int DEPTH  = 15,
    parameter int DATA_W = 32
) (
    input logic                 clk,
    input logic                 rst_n,
    rob_result_buffer_if.slave  bus
);
    localparam logic [ID_W-1:0] ONE      = ID_W'(1);
    localparam logic [ID_W-1:0] LAST_IDX = ID_W'(DEPTH - 1);
    localparam logic [ID_W-1:0] FULL_CNT = ID_W'(DEPTH);

    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [DEPTH-1:0]  done_q, done_d;
    logic [4:0]        rd_q    [DEPTH];
    logic [4:0]        rd_d    [DEPTH];
    logic [DATA_W-1:0] value_q [DEPTH];
    logic [DATA_W-1:0] value_d [DEPTH];

    logic [ID_W-1:0]   head_q, head_d;
    logic [ID_W-1:0]   tail_q, tail_d;
    logic [ID_W-1:0]   count_q, count_d;
    logic              rob_full_q, rob_full_d;

    logic              commit_valid_q, commit_valid_d;
    logic [ID_W-1:0]   commit_rob_id_q, commit_rob_id_d;
    logic [4:0]        commit_rd_q, commit_rd_d;
    logic [DATA_W-1:0] commit_value_q, commit_value_d;

    logic              alloc_acc;
    logic              commit_fire;
    logic [ID_W-1:0]   rs_idx, ls_idx, q1_idx, q2_idx;

    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] p);
        return (p == LAST_IDX) ? '0 : p + ONE;
    endfunction

    // ROB ID i+1 lives in entry i; tag 0 never reaches an array index thanks to the != 0 guards
    assign rs_idx = bus.rob_id_from_rs_cdb - ONE;
    assign ls_idx = bus.rob_id_from_ls_cdb - ONE;
    assign q1_idx = bus.Q1_query - ONE;
    assign q2_idx = bus.Q2_query - ONE;

    assign alloc_acc   = bus.alloc_valid && !rob_full_q;
    assign commit_fire = busy_q[head_q] && done_q[head_q];

    always_comb begin
        busy_d          = busy_q;
        done_d          = done_q;
        rd_d            = rd_q;
        value_d         = value_q;
        head_d          = head_q;
        tail_d          = tail_q;
        count_d         = count_q;
        commit_valid_d  = 1'b0;
        commit_rob_id_d = commit_rob_id_q;
        commit_rd_d     = commit_rd_q;
        commit_value_d  = commit_value_q;

        if (bus.flush) begin
            busy_d          = '0;
            done_d          = '0;
            head_d          = '0;
            tail_d          = '0;
            count_d         = '0;
            commit_rob_id_d = '0;
            commit_rd_d     = '0;
            commit_value_d  = '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_d[i]    = '0;
                value_d[i] = '0;
            end
        end else begin
            // ls is applied first so that rs overwrites it when both tags match
            if (bus.valid_from_ls_cdb && (bus.rob_id_from_ls_cdb != '0) && busy_q[ls_idx]) begin
                done_d[ls_idx]  = 1'b1;
                value_d[ls_idx] = bus.result_from_ls_cdb;
            end
            if (bus.valid_from_rs_cdb && (bus.rob_id_from_rs_cdb != '0) && busy_q[rs_idx]) begin
                done_d[rs_idx]  = 1'b1;
                value_d[rs_idx] = bus.result_from_rs_cdb;
            end

            if (commit_fire) begin
                commit_valid_d  = 1'b1;
                commit_rob_id_d = head_q + ONE;
                commit_rd_d     = rd_q[head_q];
                commit_value_d  = value_q[head_q];
                busy_d[head_q]  = 1'b0;
                done_d[head_q]  = 1'b0;
                head_d          = wrap_inc(head_q);
            end

            // tail never aliases a busy head here: alloc is blocked whenever the buffer is full
            if (alloc_acc) begin
                busy_d[tail_q] = 1'b1;
                done_d[tail_q] = 1'b0;
                rd_d[tail_q]   = bus.alloc_rd;
                tail_d         = wrap_inc(tail_q);
            end

            if (alloc_acc && !commit_fire) begin
                count_d = count_q + ONE;
            end else if (!alloc_acc && commit_fire) begin
                count_d = count_q - ONE;
            end
        end

        rob_full_d = (count_d == FULL_CNT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q          <= '0;
            done_q          <= '0;
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            rob_full_q      <= 1'b0;
            commit_valid_q  <= 1'b0;
            commit_rob_id_q <= '0;
            commit_rd_q     <= '0;
            commit_value_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]    <= '0;
                value_q[i] <= '0;
            end
        end else begin
            busy_q          <= busy_d;
            done_q          <= done_d;
            rd_q            <= rd_d;
            value_q         <= value_d;
            head_q          <= head_d;
            tail_q          <= tail_d;
            count_q         <= count_d;
            rob_full_q      <= rob_full_d;
            commit_valid_q  <= commit_valid_d;
            commit_rob_id_q <= commit_rob_id_d;
            commit_rd_q     <= commit_rd_d;
            commit_value_q  <= commit_value_d;
        end
    end

    // Queries see registered state only; same-cycle CDB bypass lives in the forwarding unit
    assign bus.Q1_ready_from_rob  = (bus.Q1_query != '0) && busy_q[q1_idx] && done_q[q1_idx];
    assign bus.Q2_ready_from_rob  = (bus.Q2_query != '0) && busy_q[q2_idx] && done_q[q2_idx];
    assign bus.V1_result_from_rob = bus.Q1_ready_from_rob ? value_q[q1_idx] : '0;
    assign bus.V2_result_from_rob = bus.Q2_ready_from_rob ? value_q[q2_idx] : '0;

    assign bus.alloc_rob_id  = tail_q + ONE;
    assign bus.rob_full      = rob_full_q;
    assign bus.commit_valid  = commit_valid_q;
    assign bus.commit_rob_id = commit_rob_id_q;
    assign bus.commit_rd     = commit_rd_q;
    assign bus.commit_value  = commit_value_q;
endmodule

// File: tb/tb_rob_result_buffer.sv
// Bench for rob_result_buffer: a queue-based program-order model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_rob_result_buffer;
    localparam int ID_W   = 4;
    localparam int DEPTH  = 15;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rob_result_buffer_if #(.ID_W(ID_W), .DATA_W(DATA_W)) bus ();

    rob_result_buffer #(.ID_W(ID_W), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: entries keyed by ROB ID, program order kept as a queue of IDs
    bit                m_busy [1:DEPTH];
    bit                m_done [1:DEPTH];
    logic [4:0]        m_rd   [1:DEPTH];
    logic [DATA_W-1:0] m_val  [1:DEPTH];
    int                order[$];
    int                next_id;
    bit                m_full;
    bit                m_cv;
    int                m_cid;
    logic [4:0]        m_crd;
    logic [DATA_W-1:0] m_cval;

    task automatic model_reset();
        for (int i = 1; i <= DEPTH; i++) begin
            m_busy[i] = 1'b0;
            m_done[i] = 1'b0;
            m_rd[i]   = '0;
            m_val[i]  = '0;
        end
        order.delete();
        next_id = 1;
        m_full  = 1'b0;
        m_cv    = 1'b0;
        m_cid   = 0;
        m_crd   = '0;
        m_cval  = '0;
    endtask

    task automatic model_capture(input logic v, input int tag, input logic [DATA_W-1:0] val);
        if (v && tag != 0 && m_busy[tag]) begin
            m_done[tag] = 1'b1;
            m_val[tag]  = val;
        end
    endtask

    task automatic model_step();
        bit fire;
        int hid;
        if (bus.flush) begin
            model_reset();
        end else begin
            fire = (order.size() > 0) && m_done[order[0]];
            hid  = fire ? order[0] : 0;
            m_cv = fire;
            if (fire) begin
                m_cid  = hid;
                m_crd  = m_rd[hid];
                m_cval = m_val[hid];
            end
            model_capture(bus.valid_from_ls_cdb, int'(bus.rob_id_from_ls_cdb), bus.result_from_ls_cdb);
            model_capture(bus.valid_from_rs_cdb, int'(bus.rob_id_from_rs_cdb), bus.result_from_rs_cdb);
            if (fire) begin
                void'(order.pop_front());
                m_busy[hid] = 1'b0;
                m_done[hid] = 1'b0;
            end
            if (bus.alloc_valid && !m_full) begin
                m_busy[next_id] = 1'b1;
                m_done[next_id] = 1'b0;
                m_rd[next_id]   = bus.alloc_rd;
                order.push_back(next_id);
                next_id = (next_id == DEPTH) ? 1 : next_id + 1;
            end
            m_full = (order.size() == DEPTH);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    function automatic bit exp_ready(input logic [ID_W-1:0] q);
        if (q == '0) return 1'b0;
        return m_busy[int'(q)] && m_done[int'(q)];
    endfunction

    function automatic logic [DATA_W-1:0] exp_val(input logic [ID_W-1:0] q);
        return exp_ready(q) ? m_val[int'(q)] : '0;
    endfunction

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (rst_n) begin
            check_output("alloc_rob_id", bus.alloc_rob_id, next_id);
            check_output("rob_full", bus.rob_full, m_full);
            check_output("Q1_ready", bus.Q1_ready_from_rob, exp_ready(bus.Q1_query));
            check_output("Q2_ready", bus.Q2_ready_from_rob, exp_ready(bus.Q2_query));
            check_output("V1", bus.V1_result_from_rob, exp_val(bus.Q1_query));
            check_output("V2", bus.V2_result_from_rob, exp_val(bus.Q2_query));
            check_output("commit_valid", bus.commit_valid, m_cv);
            if (m_cv) begin
                check_output("commit_rob_id", bus.commit_rob_id, m_cid);
                check_output("commit_rd", bus.commit_rd, m_crd);
                check_output("commit_value", bus.commit_value, m_cval);
            end
        end
    end

    task automatic idle_inputs();
        bus.flush              = 1'b0;
        bus.alloc_valid        = 1'b0;
        bus.alloc_rd           = '0;
        bus.valid_from_rs_cdb  = 1'b0;
        bus.rob_id_from_rs_cdb = '0;
        bus.result_from_rs_cdb = '0;
        bus.valid_from_ls_cdb  = 1'b0;
        bus.rob_id_from_ls_cdb = '0;
        bus.result_from_ls_cdb = '0;
        bus.Q1_query           = '0;
        bus.Q2_query           = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic apply_stimulus(input bit alloc, input int rd,
                                  input bit rs_v, input int rs_id, input logic [DATA_W-1:0] rs_val,
                                  input bit ls_v, input int ls_id, input logic [DATA_W-1:0] ls_val);
        bus.alloc_valid        = alloc;
        bus.alloc_rd           = 5'(rd);
        bus.valid_from_rs_cdb  = rs_v;
        bus.rob_id_from_rs_cdb = ID_W'(rs_id);
        bus.result_from_rs_cdb = rs_val;
        bus.valid_from_ls_cdb  = ls_v;
        bus.rob_id_from_ls_cdb = ID_W'(ls_id);
        bus.result_from_ls_cdb = ls_val;
    endtask

    task automatic do_flush();
        bus.flush = 1'b1;
        next_cycle();
    endtask

    task automatic expect_commit(input string name, input int id, input int rd,
                                 input logic [DATA_W-1:0] val, input int budget);
        bit found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (bus.commit_valid) begin
                found = 1'b1;
                check_output({name, "_id"}, bus.commit_rob_id, id);
                check_output({name, "_rd"}, bus.commit_rd, rd);
                check_output({name, "_value"}, bus.commit_value, val);
            end
            next_cycle();
        end
        if (!found) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL %s: no commit within %0d cycles, expected id %0d", name, budget, id);
        end
    endtask

    task automatic expect_no_commit(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_output("no_commit", bus.commit_valid, 1'b0);
            next_cycle();
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        #22 rst_n = 1'b1;
        next_cycle();

        // Reset state
        @(negedge clk);
        check_output("rst_commit_valid", bus.commit_valid, 1'b0);
        check_output("rst_commit_rob_id", bus.commit_rob_id, 0);
        check_output("rst_commit_rd", bus.commit_rd, 0);
        check_output("rst_commit_value", bus.commit_value, 0);
        check_output("rst_rob_full", bus.rob_full, 1'b0);
        check_output("rst_alloc_rob_id", bus.alloc_rob_id, 1);
        next_cycle();

        // Single allocate, ls capture, query, commit
        apply_stimulus(1, 5, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check_output("t1_alloc_id", bus.alloc_rob_id, 1);
        next_cycle();
        apply_stimulus(0, 0, 0, 0, 0, 1, 1, 32'hDEAD);
        next_cycle();
        bus.Q1_query = 4'd1;
        @(negedge clk);
        check_output("t1_q1_ready", bus.Q1_ready_from_rob, 1'b1);
        check_output("t1_v1", bus.V1_result_from_rob, 32'hDEAD);
        check_output("t1_no_commit_yet", bus.commit_valid, 1'b0);
        next_cycle();
        expect_commit("t1_commit", 1, 5, 32'hDEAD, 1);

        // Out-of-order completion, in-order commit
        do_flush();
        for (int i = 1; i <= 3; i++) begin
            apply_stimulus(1, i + 10, 0, 0, 0, 0, 0, 0);
            next_cycle();
        end
        apply_stimulus(0, 0, 1, 3, 32'd7, 0, 0, 0);
        next_cycle();
        apply_stimulus(0, 0, 1, 1, 32'd9, 0, 0, 0);
        next_cycle();
        expect_commit("t2_c1", 1, 11, 32'd9, 3);
        expect_no_commit(2);
        apply_stimulus(0, 0, 1, 2, 32'h22, 0, 0, 0);
        next_cycle();
        expect_commit("t2_c2", 2, 12, 32'h22, 3);
        expect_commit("t2_c3", 3, 13, 32'd7, 2);

        // Fill to 15, ignored 16th, commit while full, wrap-around allocation
        do_flush();
        for (int i = 1; i <= DEPTH; i++) begin
            apply_stimulus(1, i, 0, 0, 0, 0, 0, 0);
            next_cycle();
        end
        @(negedge clk);
        check_output("t3_full", bus.rob_full, 1'b1);
        apply_stimulus(1, 31, 0, 0, 0, 0, 0, 0);
        next_cycle();
        apply_stimulus(1, 30, 0, 0, 0, 1, 1, 32'h100);
        next_cycle();
        apply_stimulus(1, 29, 0, 0, 0, 0, 0, 0);
        next_cycle();
        @(negedge clk);
        check_output("t3_commit_valid", bus.commit_valid, 1'b1);
        check_output("t3_commit_id", bus.commit_rob_id, 1);
        check_output("t3_commit_value", bus.commit_value, 32'h100);
        check_output("t3_full_dropped", bus.rob_full, 1'b0);
        apply_stimulus(1, 7, 0, 0, 0, 0, 0, 0);
        check_output("t3_wrap_id", bus.alloc_rob_id, 1);
        next_cycle();
        @(negedge clk);
        check_output("t3_full_again", bus.rob_full, 1'b1);
        check_output("t3_next_id", bus.alloc_rob_id, 2);

        // Both CDBs on the same tag, then two different tags in one cycle
        do_flush();
        for (int i = 1; i <= 3; i++) begin
            apply_stimulus(1, i, 0, 0, 0, 0, 0, 0);
            next_cycle();
        end
        apply_stimulus(0, 0, 1, 2, 32'h11, 1, 2, 32'h22);
        next_cycle();
        bus.Q1_query = 4'd2;
        bus.Q2_query = 4'd1;
        @(negedge clk);
        check_output("t4_v1_rs_wins", bus.V1_result_from_rob, 32'h11);
        check_output("t4_q2_not_done", bus.Q2_ready_from_rob, 1'b0);
        next_cycle();
        apply_stimulus(0, 0, 1, 1, 32'h33, 1, 3, 32'h44);
        next_cycle();
        expect_commit("t4_c1", 1, 1, 32'h33, 3);
        expect_commit("t4_c2", 2, 2, 32'h11, 2);
        expect_commit("t4_c3", 3, 3, 32'h44, 2);

        // Zero tag and non-busy tags
        bus.Q1_query = 4'd0;
        bus.Q2_query = 4'd5;
        @(negedge clk);
        check_output("t5_q1_zero", bus.Q1_ready_from_rob, 1'b0);
        check_output("t5_v2_nonbusy", bus.V2_result_from_rob, 0);
        next_cycle();
        apply_stimulus(0, 0, 1, 0, 32'hAAAA, 1, 9, 32'hBBBB);
        next_cycle();
        expect_no_commit(2);

        // Flush with pending entries and done head, alongside a CDB
        do_flush();
        for (int i = 1; i <= 4; i++) begin
            apply_stimulus(1, i + 20, 0, 0, 0, 0, 0, 0);
            next_cycle();
        end
        apply_stimulus(0, 0, 1, 1, 32'h55, 0, 0, 0);
        next_cycle();
        apply_stimulus(1, 3, 0, 0, 0, 1, 2, 32'h66);
        bus.flush = 1'b1;
        next_cycle();
        @(negedge clk);
        check_output("t6_no_commit", bus.commit_valid, 1'b0);
        check_output("t6_alloc_id", bus.alloc_rob_id, 1);
        check_output("t6_full", bus.rob_full, 1'b0);
        next_cycle();
        expect_no_commit(3);

        // Reset arriving while a commit pulse is high
        apply_stimulus(1, 3, 0, 0, 0, 0, 0, 0);
        next_cycle();
        apply_stimulus(0, 0, 1, 1, 32'hBEEF, 0, 0, 0);
        next_cycle();
        next_cycle();
        check_output("t7_commit_before_rst", bus.commit_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check_output("t7_rst_commit_valid", bus.commit_valid, 1'b0);
        check_output("t7_rst_commit_value", bus.commit_value, 0);
        check_output("t7_rst_alloc_id", bus.alloc_rob_id, 1);
        @(posedge clk);
        #2 rst_n = 1'b1;
        next_cycle();
        expect_no_commit(2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
